// File: rtl/duty_fader_pkg.sv
// duty_fader_pkg: shared constants for the breathing-fade duty generator.
//   - default duty / prescaler widths and the full-scale duty value
//   - the substitute used when step_size is programmed as zero
//   - 3-bit FSM state encodings
package duty_fader_pkg;

    localparam int DUTY_W_DEF = 8;
    localparam int DIV_W_DEF  = 16;

    localparam logic [DUTY_W_DEF-1:0] DUTY_MAX = '1;

    // A zero step would stall the fade forever, so it is promoted to this.
    localparam logic [3:0] STEP_ZERO_SUB = 4'd1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_UP      = 3'd1;
    localparam logic [2:0] ST_HOLD_HI = 3'd2;
    localparam logic [2:0] ST_DOWN    = 3'd3;
    localparam logic [2:0] ST_HOLD_LO = 3'd4;

    function automatic logic [3:0] eff_step(input logic [3:0] step_size);
        return (step_size == 4'd0) ? STEP_ZERO_SUB : step_size;
    endfunction

endpackage

// File: rtl/duty_fader_if.sv
// duty_fader_if: configuration and output bundle of duty_fader.
//   enable     : run the fade while high
//   step_div   : clocks per step tick, minus one
//   step_size  : duty change per tick (0 acts as 1)
//   hold_ticks : ticks spent at each extreme, minus one
//   duty       : registered duty word for the PWM stage
//   peak       : one-cycle pulse on first all-ones duty
//   trough     : one-cycle pulse on first zero duty after a descent
//   busy       : high whenever the fader is not idle
// master = the controller driving the configuration, slave = duty_fader.
interface duty_fader_if
    import duty_fader_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) ();

    logic              enable;
    logic [DIV_W-1:0]  step_div;
    logic [3:0]        step_size;
    logic [7:0]        hold_ticks;
    logic [DUTY_W-1:0] duty;
    logic              peak;
    logic              trough;
    logic              busy;

    modport master (
        output enable, step_div, step_size, hold_ticks,
        input  duty, peak, trough, busy
    );

    modport slave (
        input  enable, step_div, step_size, hold_ticks,
        output duty, peak, trough, busy
    );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running step-rate divider.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : hold the counter at zero and suppress tick
//   div        : clocks per tick, minus one (live)
//   tick       : one-cycle strobe when the count has reached div
// The compare is >= so that lowering div below the running count
// produces a tick right away instead of waiting for a counter wrap.
module tick_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = !clear && (cnt >= div);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/duty_fader.sv
// duty_fader: triangle "breathing" duty generator for a PWM stage.
//   clk, rst_n : clock (shared with the PWM stage), async active-low reset
//   bus        : duty_fader_if slave port (configuration in, duty/pulses out)
// Sequence: IDLE -> UP -> HOLD_HI -> DOWN -> HOLD_LO -> UP/IDLE.
// Dropping enable never cuts the output: UP and HOLD_HI divert to DOWN,
// and the fade only parks in IDLE after a full descent to zero.
module duty_fader
    import duty_fader_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    duty_fader_if.slave bus
);

    localparam logic [DUTY_W-1:0] MAX = {DUTY_W{1'b1}};

    logic [2:0]        state;
    logic [DUTY_W-1:0] duty_q;
    logic              peak_q;
    logic              trough_q;
    logic [7:0]        hold_cnt;

    logic              tick;
    logic              idle;
    logic [DUTY_W:0]   step_ext;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_diff;
    logic [DUTY_W-1:0] up_next;
    logic [DUTY_W-1:0] dn_next;
    logic              hold_done;

    assign idle = (state == ST_IDLE);

    tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (idle),
        .div   (bus.step_div),
        .tick  (tick)
    );

    // One extra bit of headroom: the carry flags overshoot past full scale,
    // the borrow flags undershoot below zero; either clamps instead of wrapping.
    assign step_ext = {{(DUTY_W-3){1'b0}}, eff_step(bus.step_size)};
    assign up_sum   = {1'b0, duty_q} + step_ext;
    assign dn_diff  = {1'b0, duty_q} - step_ext;
    assign up_next  = up_sum[DUTY_W]  ? MAX : up_sum[DUTY_W-1:0];
    assign dn_next  = dn_diff[DUTY_W] ? '0  : dn_diff[DUTY_W-1:0];

    assign hold_done = (hold_cnt == bus.hold_ticks);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            duty_q   <= '0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            hold_cnt <= '0;
        end else begin
            // NOTE: pulses default low each cycle and are only raised by the
            // transition that creates them, which keeps them one cycle wide.
            peak_q   <= 1'b0;
            trough_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    duty_q   <= '0;
                    hold_cnt <= '0;
                    if (bus.enable) begin
                        state <= ST_UP;
                    end
                end

                ST_UP: begin
                    if (tick) begin
                        if (!bus.enable) begin
                            // Reverse from the current level, no last increment.
                            state <= ST_DOWN;
                        end else begin
                            duty_q <= up_next;
                            if (up_next == MAX) begin
                                state  <= ST_HOLD_HI;
                                peak_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_HOLD_HI: begin
                    if (tick) begin
                        if (!bus.enable || hold_done) begin
                            state    <= ST_DOWN;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end

                ST_DOWN: begin
                    if (tick) begin
                        duty_q <= dn_next;
                        if (dn_next == '0) begin
                            state    <= ST_HOLD_LO;
                            trough_q <= 1'b1;
                        end
                    end
                end

                ST_HOLD_LO: begin
                    if (tick) begin
                        if (hold_done) begin
                            state    <= bus.enable ? ST_UP : ST_IDLE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    duty_q   <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.duty   = duty_q;
    assign bus.peak   = peak_q;
    assign bus.trough = trough_q;
    assign bus.busy   = !idle;

endmodule
